// File: rtl/if_stage.sv
// Instruction-fetch stage with integrated IF/ID pipeline register.
// Owns the PC and issues one request at a time to a variable-latency
// instruction memory. It handles decode stall, flush/redirect and the
// branch delay slot, and delivers {pc, inst} to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        kill_reg, kill_next;
    logic        pend_reg, pend_next;
    logic [31:0] pend_tgt_reg, pend_tgt_next;
    logic [31:0] buf_reg, buf_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_inst_reg, id_inst_next;
    logic        id_valid_reg, id_valid_next;

    logic        deliver;
    logic [31:0] deliver_inst;
    logic        branch_take;
    logic [31:0] branch_tgt;
    logic [31:0] flush_tgt;
    logic [31:0] adv_pc;

    // Redirect targets are word aligned; the branch flag only means
    // something while decode holds a real instruction and is moving.
    assign branch_tgt  = branch_target_i & 32'hFFFF_FFFC;
    assign flush_tgt   = flush_pc_i & 32'hFFFF_FFFC;
    assign branch_take = branch_flag_i & id_valid_reg & ~stall_i;
    assign adv_pc      = branch_take ? branch_tgt :
                         pend_reg    ? pend_tgt_reg :
                                       pc_reg + 32'd4;

    assign imem_req_o  = (state_reg == S_FETCH);
    assign imem_addr_o = pc_reg;
    assign id_pc_o     = id_pc_reg;
    assign id_inst_o   = id_inst_reg;
    assign id_valid_o  = id_valid_reg;

    // State register: every register returns to its reset value on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC;
            kill_reg     <= 1'b0;
            pend_reg     <= 1'b0;
            pend_tgt_reg <= 32'h0;
            buf_reg      <= 32'h0;
            id_pc_reg    <= 32'h0;
            id_inst_reg  <= 32'h0;
            id_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            kill_reg     <= kill_next;
            pend_reg     <= pend_next;
            pend_tgt_reg <= pend_tgt_next;
            buf_reg      <= buf_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
            id_valid_reg <= id_valid_next;
        end
    end

    // Next-state, PC selection and IF/ID update; flush overrides everything.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        kill_next     = kill_reg;
        pend_next     = pend_reg;
        pend_tgt_next = pend_tgt_reg;
        buf_next      = buf_reg;
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        id_valid_next = id_valid_reg;
        deliver       = 1'b0;
        deliver_inst  = 32'h0;

        if (flush_i) begin
            pc_next       = flush_tgt;
            pend_next     = 1'b0;
            id_pc_next    = 32'h0;
            id_inst_next  = 32'h0;
            id_valid_next = 1'b0;
            buf_next      = 32'h0;
            case (state_reg)
                S_FETCH: begin
                    // The request issued this cycle is now stale.
                    state_next = S_WAIT;
                    kill_next  = 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        // The response is consumed and dropped right now, so
                        // nothing is outstanding; waiting with kill set would
                        // never see another response.
                        state_next = S_FETCH;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next  = 1'b1;
                    end
                end
                default: begin
                    // IDLE or HOLD: no request in flight, buffered word dropped.
                    state_next = S_FETCH;
                    kill_next  = 1'b0;
                end
            endcase
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_reg) begin
                            kill_next  = 1'b0;
                            state_next = S_FETCH;
                        end else if (!stall_i) begin
                            deliver      = 1'b1;
                            deliver_inst = imem_rdata_i;
                            state_next   = S_FETCH;
                        end else begin
                            buf_next   = imem_rdata_i;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        deliver      = 1'b1;
                        deliver_inst = buf_reg;
                        state_next   = S_FETCH;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            if (deliver) begin
                pc_next       = adv_pc;
                pend_next     = 1'b0;
                id_pc_next    = pc_reg;
                id_inst_next  = deliver_inst;
                id_valid_next = 1'b1;
            end else begin
                if (!stall_i) begin
                    id_pc_next    = 32'h0;
                    id_inst_next  = 32'h0;
                    id_valid_next = 1'b0;
                end
                // The delay slot is still being fetched: remember where to go
                // once it has been delivered.
                if (branch_take && (state_reg == S_FETCH || state_reg == S_WAIT)) begin
                    pend_next     = 1'b1;
                    pend_tgt_next = branch_tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: cycle table for sequential fetch, hand
// sequences for stall, delay slot, flush and reset, a memory model with
// programmable latency, and a scoreboard of expected deliveries.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_flag_i;
    logic [31:0] flush_pc_i, branch_target_i;
    logic        imem_req_o, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o;

    // Second instance for the address-wrap case.
    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_pc, w_inst;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .flush_pc_i(flush_pc_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0),
        .flush_pc_i(32'h0), .branch_flag_i(1'b0),
        .branch_target_i(32'h0), .imem_req_o(w_req),
        .imem_addr_o(w_addr), .imem_rvalid_i(w_rvalid),
        .imem_rdata_i(32'h1234_5678), .id_pc_o(w_pc),
        .id_inst_o(w_inst), .id_valid_o(w_valid)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    int          n_total = 0;
    int          n_bad   = 0;
    exp_t        sb[$];
    logic [31:0] w_rlog[$];
    logic [31:0] w_dlog[$];
    vec_t        tbl[8];

    // memory model state
    int          lat = 1;
    bit          mem_busy = 0, mem_kill = 0, rsp_live = 0;
    int          mem_cd = 0;
    logic [31:0] mem_addr = 0, rsp_pc = 0;
    bit          mem_ovr_en = 0;
    logic [31:0] mem_ovr = 0;
    bit          prev_stall = 0, prev_flush = 0, prev_rst = 1, w_req_prev = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock; afterwards the bench sits #1 past the edge, the
    // memory response for the new cycle is driven and deliveries are scored.
    task automatic cycle();
        exp_t e;
        if (rsp_live && !flush_i && !rst) sb.push_back('{rsp_pc, imem_rdata_i});
        if (flush_i && mem_busy) mem_kill = 1;
        if (rst) begin
            mem_busy = 0;
            mem_kill = 0;
        end
        prev_stall = stall_i;
        prev_flush = flush_i;
        prev_rst   = rst;
        @(posedge clk);
        #1;
        if (!prev_stall && !prev_flush && !prev_rst && id_valid_o) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_unexpected: got pc=%h nothing expected", id_pc_o);
            end else begin
                e = sb.pop_front();
                $display("deliver pc=%h inst=%h", id_pc_o, id_inst_o);
                chk("sb_pc", id_pc_o, e.pc);
                chk("sb_inst", id_inst_o, e.inst);
            end
        end
        imem_rvalid_i = 0;
        imem_rdata_i  = 0;
        rsp_live      = 0;
        if (mem_busy) begin
            mem_cd--;
            if (mem_cd == 0) begin
                mem_busy      = 0;
                imem_rvalid_i = 1;
                imem_rdata_i  = mem_ovr_en ? mem_ovr : mem_word(mem_addr);
                mem_ovr_en    = 0;
                rsp_live      = !mem_kill;
                rsp_pc        = mem_addr;
                mem_kill      = 0;
            end
        end
        if (imem_req_o) begin
            mem_busy = 1;
            mem_cd   = lat;
            mem_addr = imem_addr_o;
        end
        w_rvalid   = w_req_prev && !prev_rst;
        w_req_prev = w_req;
        if (w_req && w_rlog.size() < 4) w_rlog.push_back(w_addr);
        if (w_valid && !prev_rst && w_dlog.size() < 4) begin
            w_dlog.push_back(w_pc);
            chk("wrap_inst", w_inst, 32'h1234_5678);
        end
    endtask

    task automatic wait_req(input string nm, input logic [31:0] a);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (imem_req_o) seen = 1;
        end
        if (!seen) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: no request within 20 cycles, expected addr %h", nm, a);
        end else begin
            chk(nm, imem_addr_o, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; flush_pc_i = 0;
        branch_flag_i = 0; branch_target_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = 0; w_rvalid = 0;

        // cycle-by-cycle expectations from the first cycle after reset, k=1
        tbl[0] = '{1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000, mem_word(32'hBFC0_0000)};
        tbl[4] = '{1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004, mem_word(32'hBFC0_0004)};
        tbl[6] = '{1'b0, 32'hBFC0_0008, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008, mem_word(32'hBFC0_0008)};

        repeat (3) cycle();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycle();
            chk($sformatf("seq_req[%0d]", i), 32'(imem_req_o), 32'(tbl[i].req));
            chk($sformatf("seq_addr[%0d]", i), imem_addr_o, tbl[i].addr);
            chk($sformatf("seq_valid[%0d]", i), 32'(id_valid_o), 32'(tbl[i].valid));
            chk($sformatf("seq_pc[%0d]", i), id_pc_o, tbl[i].pc);
            chk($sformatf("seq_inst[%0d]", i), id_inst_o, tbl[i].inst);
        end

        // Stall: response lands while decode is stalled; held in HOLD.
        mem_ovr_en = 1;
        mem_ovr    = 32'h3421_0001;
        stall_i    = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_noreq", 32'(imem_req_o), 32'h0);
            chk("stall_hold_pc", id_pc_o, 32'hBFC0_0008);
            chk("stall_hold_valid", 32'(id_valid_o), 32'h1);
            if (i == 3) stall_i = 0;
        end
        cycle();
        chk("stall_rel_inst", id_inst_o, 32'h3421_0001);
        chk("stall_rel_pc", id_pc_o, 32'hBFC0_000C);
        chk("stall_rel_req", 32'(imem_req_o), 32'h1);
        chk("stall_rel_addr", imem_addr_o, 32'hBFC0_0010);

        // Redirect to 0x100 while the BFC00010 fetch is being issued.
        flush_i    = 1;
        flush_pc_i = 32'h0000_0100;
        cycle();
        flush_i = 0;
        chk("flush1_valid", 32'(id_valid_o), 32'h0);
        wait_req("ds_req_100", 32'h0000_0100);
        lat = 3;
        wait_req("ds_req_104", 32'h0000_0104);
        chk("ds_id_pc_100", id_pc_o, 32'h0000_0100);
        stall_i = 1;
        cycle();
        // 0x104 is in WAIT now; decode resolves the branch at 0x100.
        stall_i         = 0;
        branch_flag_i   = 1;
        branch_target_i = 32'h0000_0201;
        chk("ds_in_wait", 32'(imem_req_o), 32'h0);
        cycle();
        branch_flag_i   = 0;
        branch_target_i = 32'h0;
        lat = 1;
        wait_req("ds_req_200", 32'h0000_0200);
        chk("ds_slot_pc", id_pc_o, 32'h0000_0104);
        chk("ds_slot_valid", 32'(id_valid_o), 32'h1);
        lat = 3;
        wait_req("ds_req_204", 32'h0000_0204);

        // Flush during WAIT with k=3; the late response must be discarded.
        cycle();
        flush_i    = 1;
        flush_pc_i = 32'h0000_0182;
        cycle();
        flush_i = 0;
        chk("fl_valid", 32'(id_valid_o), 32'h0);
        chk("fl_inst", id_inst_o, 32'h0);
        chk("fl_pc", id_pc_o, 32'h0);
        chk("fl_noreq", 32'(imem_req_o), 32'h0);
        wait_req("fl_req_180", 32'h0000_0180);
        chk("fl_no_deliver", 32'(id_valid_o), 32'h0);

        // Reset pulse mid-WAIT, then a late response while IDLE.
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_addr", imem_addr_o, 32'hBFC0_0000);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'h0);
        lat = 1;
        imem_rvalid_i = 1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        cycle();
        chk("rst_first_req", 32'(imem_req_o), 32'h1);
        chk("rst_first_addr", imem_addr_o, 32'hBFC0_0000);
        chk("rst_late_ignored", 32'(id_valid_o), 32'h0);
        cycle();
        cycle();
        chk("rst_refetch_pc", id_pc_o, 32'hBFC0_0000);
        chk("rst_refetch_inst", id_inst_o, mem_word(32'hBFC0_0000));
        repeat (2) cycle();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // Wrap instance: second request and second delivery at address 0.
        if (w_rlog.size() < 2 || w_dlog.size() < 2) begin
            n_total++;
            n_bad++;
            $display("FAIL wrap_log: got %0d req %0d deliveries expected >=2 each",
                     w_rlog.size(), w_dlog.size());
        end else begin
            chk("wrap_req0", w_rlog[0], 32'hFFFF_FFFC);
            chk("wrap_req1", w_rlog[1], 32'h0000_0000);
            chk("wrap_pc0", w_dlog[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", w_dlog[1], 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
